// File: rtl/eth_pkg.sv
// Shared Ethernet/IP/UDP types for the receive path.
// Holds the byte type, the UDP header layout and the UDP parser state encoding.
package eth_pkg;

  typedef logic [7:0] byte_t;

  localparam int UDP_HDR_LEN = 8;

  typedef struct packed {
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
    logic [15:0] csum;
  } udp_hdr_t;

  typedef enum logic [1:0] {
    HDR     = 2'd0,
    PAYLOAD = 2'd1,
    DROP    = 2'd2
  } udp_state_t;

endpackage

// File: rtl/udp_parser.sv
// UDP header strip/check stage: filters on destination port, forwards payload with one-cycle latency.
// Optional macro UDP_LEN_TRIM_EN enforces the UDP length field and discards trailing padding.
module udp_parser
  import eth_pkg::*;
#(
  parameter logic [15:0] UDP_PORT = 16'd5000
) (
  input  logic        clk,
  input  logic        rst,
  input  byte_t       ip_data_in,
  input  logic        ip_byte_valid,
  input  logic        ip_eof,
  input  logic        ip_err,
  output byte_t       udp_data_out,
  output logic        udp_byte_valid,
  output logic        udp_eof,
  output logic        udp_err,
  output logic        udp_hdr_valid,
  output logic [15:0] udp_src_port,
  output logic [15:0] udp_dst_port,
  output logic [15:0] udp_len
);

  udp_state_t  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] src_q, src_d, dst_q, dst_d, len_q, len_d;

  byte_t       data_d;
  logic        bv_d, eof_d, err_d, hv_d;
  logic [15:0] src_port_d, dst_port_d, out_len_d;

`ifdef UDP_LEN_TRIM_EN
  logic [15:0] rem_q, rem_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    data_d     = '0;
    bv_d       = 1'b0;
    eof_d      = 1'b0;
    err_d      = 1'b0;
    hv_d       = 1'b0;
    src_port_d = udp_src_port;
    dst_port_d = udp_dst_port;
    out_len_d  = udp_len;
`ifdef UDP_LEN_TRIM_EN
    rem_d      = rem_q;
`endif

    if (ip_byte_valid) begin
      unique case (state_q)
        HDR: begin
          // An error byte carries no data, so it terminates the header like a short frame.
          if (ip_eof && (ip_err || cnt_q != 3'd7)) begin
            err_d = 1'b1;
            cnt_d = '0;
          end else begin
            unique case (cnt_q)
              3'd0:    src_d[15:8] = ip_data_in;
              3'd1:    src_d[7:0]  = ip_data_in;
              3'd2:    dst_d[15:8] = ip_data_in;
              3'd3:    dst_d[7:0]  = ip_data_in;
              3'd4:    len_d[15:8] = ip_data_in;
              3'd5:    len_d[7:0]  = ip_data_in;
              default: ;
            endcase

            if (cnt_q == 3'd7) begin
              cnt_d = '0;
              if (dst_q != UDP_PORT || len_q < 16'(UDP_HDR_LEN)) begin
                err_d   = 1'b1;
                state_d = ip_eof ? HDR : DROP;
              end else begin
                hv_d       = 1'b1;
                src_port_d = src_q;
                dst_port_d = dst_q;
                out_len_d  = len_q;
`ifdef UDP_LEN_TRIM_EN
                rem_d      = len_q - 16'(UDP_HDR_LEN);
`endif
                if (ip_eof)
                  state_d = HDR;
                else if (len_q == 16'(UDP_HDR_LEN))
                  state_d = DROP;
                else
                  state_d = PAYLOAD;
              end
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end

        PAYLOAD: begin
          if (ip_eof && ip_err) begin
            eof_d   = 1'b1;
            err_d   = 1'b1;
            state_d = HDR;
          end else begin
            data_d = ip_data_in;
            bv_d   = 1'b1;
            eof_d  = ip_eof;
            if (ip_eof)
              state_d = HDR;
`ifdef UDP_LEN_TRIM_EN
            // Length reached: end the payload here; anything after it is link padding.
            rem_d = rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              eof_d = 1'b1;
              if (!ip_eof)
                state_d = DROP;
            end else if (ip_eof) begin
              err_d = 1'b1;
            end
`endif
          end
        end

        DROP: begin
          if (ip_eof) begin
            state_d = HDR;
            cnt_d   = '0;
          end
        end

        default: state_d = HDR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= HDR;
      cnt_q          <= '0;
      src_q          <= '0;
      dst_q          <= '0;
      len_q          <= '0;
      udp_data_out   <= '0;
      udp_byte_valid <= 1'b0;
      udp_eof        <= 1'b0;
      udp_err        <= 1'b0;
      udp_hdr_valid  <= 1'b0;
      udp_src_port   <= '0;
      udp_dst_port   <= '0;
      udp_len        <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      src_q          <= src_d;
      dst_q          <= dst_d;
      len_q          <= len_d;
      udp_data_out   <= data_d;
      udp_byte_valid <= bv_d;
      udp_eof        <= eof_d;
      udp_err        <= err_d;
      udp_hdr_valid  <= hv_d;
      udp_src_port   <= src_port_d;
      udp_dst_port   <= dst_port_d;
      udp_len        <= out_len_d;
    end
  end

`ifdef UDP_LEN_TRIM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rem_q <= '0;
    else
      rem_q <= rem_d;
  end
`endif

endmodule

// File: tb/tb_udp_parser.sv
// Directed scoreboard bench for udp_parser: expected output events are queued as bytes are driven.
// Builds with or without UDP_LEN_TRIM_EN; the padding expectations follow the macro.
module tb_udp_parser;
  import eth_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  byte_t       ip_data_in;
  logic        ip_byte_valid, ip_eof, ip_err;
  byte_t       udp_data_out;
  logic        udp_byte_valid, udp_eof, udp_err, udp_hdr_valid;
  logic [15:0] udp_src_port, udp_dst_port, udp_len;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        bv;
    logic        eof;
    logic        err;
    logic        hv;
    logic [7:0]  data;
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
  } exp_t;

  exp_t expQ[$];

  udp_parser #(.UDP_PORT(16'd5000)) dut (
    .clk            (clk),
    .rst            (rst),
    .ip_data_in     (ip_data_in),
    .ip_byte_valid  (ip_byte_valid),
    .ip_eof         (ip_eof),
    .ip_err         (ip_err),
    .udp_data_out   (udp_data_out),
    .udp_byte_valid (udp_byte_valid),
    .udp_eof        (udp_eof),
    .udp_err        (udp_err),
    .udp_hdr_valid  (udp_hdr_valid),
    .udp_src_port   (udp_src_port),
    .udp_dst_port   (udp_dst_port),
    .udp_len        (udp_len)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input byte_t d, input logic eof, input logic err);
    @(negedge clk);
    ip_data_in    = d;
    ip_byte_valid = 1'b1;
    ip_eof        = eof;
    ip_err        = err;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ip_data_in    = '0;
      ip_byte_valid = 1'b0;
      ip_eof        = 1'b0;
      ip_err        = 1'b0;
    end
  endtask

  // Sends the first n header bytes; eof marks the last byte sent.
  task automatic sendHdr(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                         input int n, input logic eof);
    logic [63:0] h;
    h = {s, d, l, 16'hC0DE};
    for (int i = 0; i < n; i++)
      applyStimulus(h[63-8*i -: 8], eof && (i == n - 1), 1'b0);
  endtask

  task automatic pushByte(input byte_t d, input logic eof);
    expQ.push_back('{bv: 1'b1, eof: eof, err: 1'b0, hv: 1'b0, data: d, src: '0, dst: '0, len: '0});
  endtask

  task automatic pushHv(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
    expQ.push_back('{bv: 1'b0, eof: 1'b0, err: 1'b0, hv: 1'b1, data: '0, src: s, dst: d, len: l});
  endtask

  task automatic pushErr(input logic eof);
    expQ.push_back('{bv: 1'b0, eof: eof, err: 1'b1, hv: 1'b0, data: '0, src: '0, dst: '0, len: '0});
  endtask

  // Scoreboard: every active output cycle must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (udp_byte_valid || udp_eof || udp_err || udp_hdr_valid)) begin
      checks++;
      assert (expQ.size() != 0) else begin
        errors++;
        $error("[TB] FAIL unexpected_output observed=%b%b%b%b data=%0h expected=none",
               udp_byte_valid, udp_eof, udp_err, udp_hdr_valid, udp_data_out);
      end
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("flags{bv,eof,err,hv}",
                    {60'd0, udp_byte_valid, udp_eof, udp_err, udp_hdr_valid},
                    {60'd0, e.bv, e.eof, e.err, e.hv});
        if (e.bv)
          checkOutput("data", {56'd0, udp_data_out}, {56'd0, e.data});
        if (e.hv)
          checkOutput("ports{src,dst,len}", {16'd0, udp_src_port, udp_dst_port, udp_len},
                      {16'd0, e.src, e.dst, e.len});
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    ip_data_in = '0; ip_byte_valid = 1'b0; ip_eof = 1'b0; ip_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_flags", {60'd0, udp_byte_valid, udp_eof, udp_err, udp_hdr_valid}, 64'd0);
    checkOutput("reset_data", {56'd0, udp_data_out}, 64'd0);
    checkOutput("reset_ports", {16'd0, udp_src_port, udp_dst_port, udp_len}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Valid frame: 4-byte payload, eof on the last byte.
    sendHdr(16'h1234, 16'h1388, 16'h000C, 8, 1'b0);
    pushHv(16'h1234, 16'h1388, 16'h000C);
    applyStimulus(8'hDE, 1'b0, 1'b0); pushByte(8'hDE, 1'b0);
    applyStimulus(8'hAD, 1'b0, 1'b0); pushByte(8'hAD, 1'b0);
    applyStimulus(8'hBE, 1'b0, 1'b0); pushByte(8'hBE, 1'b0);
    applyStimulus(8'hEF, 1'b1, 1'b0); pushByte(8'hEF, 1'b1);
    idle(2);

    // Wrong destination port: error pulse, payload dropped, captured ports held.
    sendHdr(16'h4444, 16'h0050, 16'h000C, 8, 1'b0);
    pushErr(1'b0);
    applyStimulus(8'h01, 1'b0, 1'b0);
    applyStimulus(8'h02, 1'b0, 1'b0);
    applyStimulus(8'h03, 1'b0, 1'b0);
    applyStimulus(8'h04, 1'b1, 1'b0);
    #1;
    checkOutput("held_src_port", {48'd0, udp_src_port}, 64'h1234);
    checkOutput("held_dst_port", {48'd0, udp_dst_port}, 64'h1388);

    // Back-to-back valid frame right after the dropped one.
    sendHdr(16'h1111, 16'h1388, 16'h0009, 8, 1'b0);
    pushHv(16'h1111, 16'h1388, 16'h0009);
    applyStimulus(8'h55, 1'b1, 1'b0); pushByte(8'h55, 1'b1);

    // Length below header size, eof on byte 7: error, back to header hunting.
    sendHdr(16'h2222, 16'h1388, 16'h0004, 8, 1'b1);
    pushErr(1'b0);

    // Empty payload (len == 8) ending on byte 7: header strobe only.
    sendHdr(16'h3333, 16'h1388, 16'h0008, 8, 1'b1);
    pushHv(16'h3333, 16'h1388, 16'h0008);
    idle(1);

    // Padding: len 10 means two real payload bytes followed by four pad bytes.
    sendHdr(16'h0A0A, 16'h1388, 16'h000A, 8, 1'b0);
    pushHv(16'h0A0A, 16'h1388, 16'h000A);
`ifdef UDP_LEN_TRIM_EN
    applyStimulus(8'hA1, 1'b0, 1'b0); pushByte(8'hA1, 1'b0);
    applyStimulus(8'hA2, 1'b0, 1'b0); pushByte(8'hA2, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0);
`else
    applyStimulus(8'hA1, 1'b0, 1'b0); pushByte(8'hA1, 1'b0);
    applyStimulus(8'hA2, 1'b0, 1'b0); pushByte(8'hA2, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0); pushByte(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0); pushByte(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0); pushByte(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0); pushByte(8'h00, 1'b1);
`endif
    idle(1);

    // Upstream error on the third payload byte.
    sendHdr(16'h5555, 16'h1388, 16'h0010, 8, 1'b0);
    pushHv(16'h5555, 16'h1388, 16'h0010);
    applyStimulus(8'h10, 1'b0, 1'b0); pushByte(8'h10, 1'b0);
    applyStimulus(8'h11, 1'b0, 1'b0); pushByte(8'h11, 1'b0);
    applyStimulus(8'hFF, 1'b1, 1'b1); pushErr(1'b1);

    // Truncated header (eof on byte 5), then a back-to-back valid frame.
    sendHdr(16'h6666, 16'h1388, 16'h000B, 6, 1'b1);
    pushErr(1'b0);
    sendHdr(16'hABCD, 16'h1388, 16'h000B, 8, 1'b0);
    pushHv(16'hABCD, 16'h1388, 16'h000B);
    applyStimulus(8'h07, 1'b0, 1'b0); pushByte(8'h07, 1'b0);
    applyStimulus(8'h08, 1'b0, 1'b0); pushByte(8'h08, 1'b0);
    applyStimulus(8'h09, 1'b1, 1'b0); pushByte(8'h09, 1'b1);

    // Reset in the middle of a payload: outputs clear at once, parsing restarts at byte 0.
    sendHdr(16'h7777, 16'h1388, 16'h0010, 8, 1'b0);
    pushHv(16'h7777, 16'h1388, 16'h0010);
    applyStimulus(8'h20, 1'b0, 1'b0); pushByte(8'h20, 1'b0);
    applyStimulus(8'h21, 1'b0, 1'b0); pushByte(8'h21, 1'b0);
    applyStimulus(8'h22, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    ip_byte_valid = 1'b0;
    #1;
    checkOutput("midreset_flags", {60'd0, udp_byte_valid, udp_eof, udp_err, udp_hdr_valid}, 64'd0);
    checkOutput("midreset_data", {56'd0, udp_data_out}, 64'd0);
    checkOutput("midreset_ports", {16'd0, udp_src_port, udp_dst_port, udp_len}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    sendHdr(16'h8888, 16'h1388, 16'h0009, 8, 1'b0);
    pushHv(16'h8888, 16'h1388, 16'h0009);
    applyStimulus(8'h99, 1'b1, 1'b0); pushByte(8'h99, 1'b1);

    idle(5);
    #1;
    checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
